// File: rtl/acc_bank.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// acc_bank
//
// Bank of NACC independent DB-bit two's-complement accumulators.
// Takes the place of the single accumulator register in the processor datapath.
//
// An operation (LOAD/ADD/SUB/CLR) is requested on one accumulator through a
// 4-phase Req/Ack handshake:
//   IDLE : Req=1 latches Op/Sel/Entrada into holding registers -> EXEC
//   EXEC : result computed from the latched values, acc[Sel] and flags
//          written at the end of the cycle -> DONE
//   DONE : Ack held high while Req stays high; Req=0 -> IDLE
// Ack rises two edges after the edge that sampled Req. A complete op takes at
// least 4 cycles once the Req release is included.
//
// Parameters
//   DB    data width (signed)
//   NACC  number of accumulators (>= 2)
//   SAT   0 = wrap-around on overflow, 1 = clamp to signed max/min
//   SW    select width, derived from NACC
//
// Ports
//   clk      clock, rising edge
//   Reset_n  synchronous active-low reset
//   Entrada  operand for LOAD/ADD/SUB
//   Op       00 LOAD, 01 ADD, 10 SUB, 11 CLR
//   Sel      target accumulator
//   Req      request level (4-phase)
//   Ack      operation complete (registered)
//   Busy     high while in EXEC or DONE (registered)
//   RdSel    read-port index
//   Salida   acc[RdSel], one cycle of latency; 0 for RdSel >= NACC
//   Zero     last written result == 0
//   Neg      last written result MSB
//   Ovf      last ADD/SUB overflowed (signed)
// -----------------------------------------------------------------------------
module acc_bank #(
  parameter int DB   = 16,
  parameter int NACC = 4,
  parameter int SAT  = 0,
  parameter int SW   = $clog2(NACC)
) (
  input  logic          clk,
  input  logic          Reset_n,
  input  logic [DB-1:0] Entrada,
  input  logic [1:0]    Op,
  input  logic [SW-1:0] Sel,
  input  logic          Req,
  output logic          Ack,
  output logic          Busy,
  input  logic [SW-1:0] RdSel,
  output logic [DB-1:0] Salida,
  output logic          Zero,
  output logic          Neg,
  output logic          Ovf
);

  // Number of codes the select fields can carry; entries beyond NACC are
  // holes that read as zero and never get written.
  localparam int NPAD = 1 << SW;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DB-1:0] opnd_q, opnd_d;
  logic [DB-1:0] acc_q [NACC];
  logic [DB-1:0] acc_d [NACC];
  logic [DB-1:0] salida_q, salida_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;
  logic          ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Padded view of the bank: power-of-two sized so that both select fields
  // can index it directly, with hole entries tied to zero.
  // ---------------------------------------------------------------------------
  logic [DB-1:0] acc_pad [NPAD];
  logic [NPAD-1:0] sel_ok;

  for (genvar gi = 0; gi < NPAD; gi++) begin : g_pad
    if (gi < NACC) begin : g_live
      assign acc_pad[gi] = acc_q[gi];
      assign sel_ok[gi]  = 1'b1;
    end else begin : g_hole
      assign acc_pad[gi] = '0;
      assign sel_ok[gi]  = 1'b0;
    end
  end

  logic          sel_valid;
  logic [DB-1:0] acc_cur;

  assign sel_valid = sel_ok[sel_q];
  assign acc_cur   = acc_pad[sel_q];

  // ---------------------------------------------------------------------------
  // Datapath: ADD/SUB done at DB+1 bits so the extra bit carries the true
  // sign. A disagreement between the top two bits of the wide result means
  // the DB-bit result overflowed; the top bit then tells which direction.
  // ---------------------------------------------------------------------------
  logic [DB:0]   a_ext, b_ext, sum_ext;
  logic          ovf_raw;
  logic [DB-1:0] result;

  always_comb begin
    a_ext   = {acc_cur[DB-1], acc_cur};
    b_ext   = {opnd_q[DB-1], opnd_q};
    sum_ext = '0;
    ovf_raw = 1'b0;
    result  = '0;
    case (op_q)
      OP_LOAD: result = opnd_q;
      OP_ADD: begin
        sum_ext = a_ext + b_ext;
        ovf_raw = sum_ext[DB] ^ sum_ext[DB-1];
        result  = sum_ext[DB-1:0];
      end
      OP_SUB: begin
        sum_ext = a_ext - b_ext;
        ovf_raw = sum_ext[DB] ^ sum_ext[DB-1];
        result  = sum_ext[DB-1:0];
      end
      default: result = '0;
    endcase
    // Clamp toward the sign of the true (wide) result.
    if ((SAT != 0) && ovf_raw) begin
      result = sum_ext[DB] ? {1'b1, {(DB-1){1'b0}}} : {1'b0, {(DB-1){1'b1}}};
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake FSM, next-state and registered outputs
  // ---------------------------------------------------------------------------
  logic do_write;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sel_d    = sel_q;
    opnd_d   = opnd_q;
    ack_d    = 1'b0;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    do_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Req) begin
          op_d    = op_e'(Op);
          sel_d   = Sel;
          opnd_d  = Entrada;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Req is not looked at here; the op always runs to completion.
        state_d = S_DONE;
        // An out-of-range target leaves both the bank and the flags alone.
        if (sel_valid) begin
          do_write = 1'b1;
          zero_d   = (result == '0);
          neg_d    = result[DB-1];
          ovf_d    = ovf_raw;
        end
      end
      S_DONE: begin
        if (Req) begin
          ack_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Busy mirrors the state the FSM is about to enter.
    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    for (int i = 0; i < NACC; i++) begin
      acc_d[i] = acc_q[i];
      if (do_write && (sel_q == SW'(i))) begin
        acc_d[i] = result;
      end
    end
  end

  // Read port samples the bank before this cycle's write lands, so a
  // same-index write shows up one cycle later.
  assign salida_d = acc_pad[RdSel];

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_LOAD;
      sel_q    <= '0;
      opnd_q   <= '0;
      for (int i = 0; i < NACC; i++) begin
        acc_q[i] <= '0;
      end
      salida_q <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sel_q    <= sel_d;
      opnd_q   <= opnd_d;
      for (int i = 0; i < NACC; i++) begin
        acc_q[i] <= acc_d[i];
      end
      salida_q <= salida_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Ack    = ack_q;
  assign Busy   = busy_q;
  assign Salida = salida_q;
  assign Zero   = zero_q;
  assign Neg    = neg_q;
  assign Ovf    = ovf_q;

endmodule

// File: tb/tb_acc_bank.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_acc_bank
//
// Three instances share one stimulus stream:
//   0: NACC=4, wrap-around
//   1: NACC=4, saturating
//   2: NACC=3, wrap-around (Sel/RdSel = 3 is out of range)
// A reference model holds each bank as plain integers and applies the
// arithmetic rules directly (range test on the true sum, clamp or mask).
// -----------------------------------------------------------------------------
module tb_acc_bank;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic [15:0] Entrada;
  logic [1:0]  Op;
  logic [1:0]  Sel;
  logic        Req;
  logic [1:0]  RdSel;

  logic        ack   [NI];
  logic        busy  [NI];
  logic [15:0] salida[NI];
  logic        zero  [NI];
  logic        neg   [NI];
  logic        ovf   [NI];

  always #5 clk = ~clk;

  acc_bank #(.DB(16), .NACC(4), .SAT(0)) u_wrap (
    .clk(clk), .Reset_n(Reset_n), .Entrada(Entrada), .Op(Op), .Sel(Sel),
    .Req(Req), .Ack(ack[0]), .Busy(busy[0]), .RdSel(RdSel),
    .Salida(salida[0]), .Zero(zero[0]), .Neg(neg[0]), .Ovf(ovf[0])
  );

  acc_bank #(.DB(16), .NACC(4), .SAT(1)) u_sat (
    .clk(clk), .Reset_n(Reset_n), .Entrada(Entrada), .Op(Op), .Sel(Sel),
    .Req(Req), .Ack(ack[1]), .Busy(busy[1]), .RdSel(RdSel),
    .Salida(salida[1]), .Zero(zero[1]), .Neg(neg[1]), .Ovf(ovf[1])
  );

  acc_bank #(.DB(16), .NACC(3), .SAT(0)) u_odd (
    .clk(clk), .Reset_n(Reset_n), .Entrada(Entrada), .Op(Op), .Sel(Sel),
    .Req(Req), .Ack(ack[2]), .Busy(busy[2]), .RdSel(RdSel),
    .Salida(salida[2]), .Zero(zero[2]), .Neg(neg[2]), .Ovf(ovf[2])
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int          nacc_of[NI] = '{4, 4, 3};
  int          sat_of [NI] = '{0, 1, 0};
  logic [15:0] macc [NI][4];
  logic        mz [NI];
  logic        mn [NI];
  logic        mo [NI];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed(input logic [15:0] v);
    return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 4; i++) macc[k][i] = '0;
      mz[k] = 1'b0;
      mn[k] = 1'b0;
      mo[k] = 1'b0;
    end
  endtask

  task automatic model_exec(input logic [1:0] op, input logic [1:0] sel, input logic [15:0] data);
    for (int k = 0; k < NI; k++) begin
      int a, e, r;
      logic ov;
      logic [15:0] w;
      if (int'(sel) >= nacc_of[k]) continue;
      a  = to_signed(macc[k][sel]);
      e  = to_signed(data);
      ov = 1'b0;
      case (op)
        2'd0:    r = e;
        2'd1:    r = a + e;
        2'd2:    r = a - e;
        default: r = 0;
      endcase
      if ((op == 2'd1 || op == 2'd2) && (r > 32767 || r < -32768)) begin
        ov = 1'b1;
        if (sat_of[k] != 0) r = (r > 0) ? 32767 : -32768;
      end
      w = 16'(r);
      macc[k][sel] = w;
      mz[k] = (w == 16'h0000);
      mn[k] = w[15];
      mo[k] = ov;
    end
  endtask

  function automatic logic [15:0] model_rd(input int k, input logic [1:0] idx);
    return (int'(idx) >= nacc_of[k]) ? 16'h0000 : macc[k][idx];
  endfunction

  function automatic logic [15:0] pick_data();
    case ($urandom_range(0, 6))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0001;
      4:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check_flags(input string tag);
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("%s_zero%0d", tag, k), 32'(zero[k]), 32'(mz[k]));
      check_eq($sformatf("%s_neg%0d",  tag, k), 32'(neg[k]),  32'(mn[k]));
      check_eq($sformatf("%s_ovf%0d",  tag, k), 32'(ovf[k]),  32'(mo[k]));
    end
  endtask

  task automatic read_at(input logic [1:0] idx);
    @(negedge clk);
    RdSel = idx;
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++)
      check_eq($sformatf("rd%0d_inst%0d", idx, k), 32'(salida[k]), 32'(model_rd(k, idx)));
  endtask

  task automatic read_all();
    for (int i = 0; i < 4; i++) read_at(2'(i));
  endtask

  // One full handshake: request, scramble inputs after capture, check Ack
  // timing and the read port around the write, hold Req, then release.
  task automatic do_op(input logic [1:0] op, input logic [1:0] sel,
                       input logic [15:0] data, input int hold);
    $display("op=%0d sel=%0d data=%04h hold=%0d", op, sel, data, hold);
    @(negedge clk);
    Op = op; Sel = sel; Entrada = data; Req = 1'b1; RdSel = sel;
    @(posedge clk); #1;                       // edge N: captured
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("busy_cap%0d", k), 32'(busy[k]), 32'd1);
      check_eq($sformatf("ack_cap%0d", k),  32'(ack[k]),  32'd0);
    end
    @(negedge clk);
    Op = 2'($urandom); Sel = 2'($urandom); Entrada = 16'($urandom);
    @(posedge clk); #1;                       // edge N+1: write lands
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("ack_exec%0d", k), 32'(ack[k]), 32'd0);
      check_eq($sformatf("rd_old%0d", k), 32'(salida[k]), 32'(model_rd(k, sel)));
    end
    model_exec(op, sel, data);
    @(posedge clk); #1;                       // edge N+2: Ack up
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("ack_done%0d", k), 32'(ack[k]), 32'd1);
      check_eq($sformatf("rd_new%0d", k), 32'(salida[k]), 32'(model_rd(k, sel)));
    end
    check_flags("op");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        check_eq($sformatf("ack_hold%0d", k),  32'(ack[k]),  32'd1);
        check_eq($sformatf("busy_hold%0d", k), 32'(busy[k]), 32'd1);
      end
    end
    @(negedge clk);
    Req = 1'b0;
    RdSel = 2'($urandom);
    @(posedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("ack_rel%0d", k),  32'(ack[k]),  32'd0);
      check_eq($sformatf("busy_rel%0d", k), 32'(busy[k]), 32'd0);
      check_eq($sformatf("rd_rand%0d", k), 32'(salida[k]), 32'(model_rd(k, RdSel)));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    Reset_n = 1'b0; Req = 1'b1; Op = 2'd0; Sel = 2'd1; Entrada = 16'hA5A5; RdSel = 2'd1;
    model_reset();

    // Reset held with Req high
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("rst_ack%0d", k),  32'(ack[k]),    32'd0);
      check_eq($sformatf("rst_busy%0d", k), 32'(busy[k]),   32'd0);
      check_eq($sformatf("rst_sal%0d", k),  32'(salida[k]), 32'd0);
    end
    check_flags("rst");
    @(negedge clk);
    Req = 1'b0; Reset_n = 1'b1;
    read_all();

    // Reset during EXEC aborts the write
    $display("reset abort during LOAD 1234");
    @(negedge clk);
    Op = 2'd0; Sel = 2'd0; Entrada = 16'h1234; Req = 1'b1; RdSel = 2'd0;
    @(posedge clk); #1;
    @(negedge clk);
    Reset_n = 1'b0; Req = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) check_eq($sformatf("abort_ack%0d", k), 32'(ack[k]), 32'd0);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      for (int k = 0; k < NI; k++) begin
        check_eq($sformatf("abort_ack_post%0d", k), 32'(ack[k]), 32'd0);
        check_eq($sformatf("abort_acc0_%0d", k), 32'(salida[k]), 32'd0);
      end
    end

    // LOAD then ADD
    do_op(2'd0, 2'd2, 16'h0010, 0);
    check_eq("load_zero", 32'(zero[0]), 32'd0);
    check_eq("load_neg",  32'(neg[0]),  32'd0);
    do_op(2'd1, 2'd2, 16'h0005, 0);
    read_at(2'd2);
    check_eq("acc2_sum", 32'(salida[0]), 32'h0015);

    // Positive overflow: wrap vs saturate, then SUB -1
    do_op(2'd0, 2'd0, 16'h7FFF, 0);
    do_op(2'd1, 2'd0, 16'h0001, 1);
    check_eq("wrap_ovf", 32'(ovf[0]), 32'd1);
    check_eq("wrap_neg", 32'(neg[0]), 32'd1);
    check_eq("sat_ovf",  32'(ovf[1]), 32'd1);
    check_eq("sat_neg",  32'(neg[1]), 32'd0);
    read_at(2'd0);
    check_eq("wrap_val", 32'(salida[0]), 32'h8000);
    check_eq("sat_val",  32'(salida[1]), 32'h7FFF);
    do_op(2'd2, 2'd0, 16'hFFFF, 0);
    check_eq("sat_sub_ovf", 32'(ovf[1]), 32'd1);
    read_at(2'd0);
    check_eq("sat_sub_val", 32'(salida[1]), 32'h7FFF);

    // SUB to zero on acc1, others untouched
    do_op(2'd0, 2'd1, 16'h0003, 0);
    do_op(2'd2, 2'd1, 16'h0003, 0);
    check_eq("sub0_zero", 32'(zero[0]), 32'd1);
    check_eq("sub0_ovf",  32'(ovf[0]),  32'd0);
    read_all();

    // Long Req hold in DONE, then an out-of-range target for NACC=3
    do_op(2'd1, 2'd2, 16'h0100, 5);
    read_all();
    do_op(2'd0, 2'd3, 16'h0055, 2);
    do_op(2'd3, 2'd3, 16'h0000, 0);
    read_all();

    // Randomised traffic
    for (int n = 0; n < 250; n++) begin
      do_op(2'($urandom), 2'($urandom), pick_data(), $urandom_range(0, 3));
      if (n % 25 == 24) read_all();
    end
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "simulation timed out");
  end

endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Parametrised successor to the single-register accumulator in the processor datapath.
- Holds NACC independent DB-bit signed accumulators.
- Executes LOAD/ADD/SUB/CLR on a selected accumulator under a 4-phase Req/Ack handshake, replacing the old every-other-WrAcc write toggle.
- Provides a registered read port and status flags (Zero/Neg/Ovf) for the control unit's branch logic.

Parameters:
- DB, 16, data width in bits; two's-complement signed.
- NACC, 4, number of accumulators; must be 2 or greater.
- SAT, 0, 0 = wrap-around arithmetic, 1 = saturate to signed max/min on overflow.
- SW, $clog2(NACC), select width (derived, not overridden).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- Reset_n  in  1  reset; synchronous, active-low.
- Entrada  in  DB  operand for LOAD/ADD/SUB.
- Op  in  2  operation: 00 LOAD, 01 ADD, 10 SUB, 11 CLR.
- Sel  in  SW  target accumulator index.
- Req  in  1  operation request; level, 4-phase.
- Ack  out  1  operation complete; registered.
- Busy  out  1  high while in EXEC or DONE; registered.
- RdSel  in  SW  read-port index.
- Salida  out  DB  acc[RdSel], registered.
- Zero  out  1  last result == 0.
- Neg  out  1  last result MSB.
- Ovf  out  1  last ADD/SUB overflowed (signed).

Behaviour:
- Reset (Reset_n=0 at a clk edge): all acc = 0, Salida = 0, Ack = 0, Busy = 0, Zero = 0, Neg = 0, Ovf = 0, state = IDLE. Overrides every other input.
- Reset mid-operation: the pending op is aborted and no acc write occurs.
- FSM state IDLE:
  - Req=1 captures Op, Sel and Entrada into holding registers, then goes to EXEC.
  - Req=0 stays in IDLE.
- FSM state EXEC, one cycle:
  - Computes the result from the captured values and writes acc[Sel] at the end of the cycle.
  - Updates the flags.
  - Goes to DONE.
- FSM state DONE:
  - Ack = 1 and stays 1 while Req = 1.
  - Req=0 drops Ack to 0 and returns to IDLE the next cycle.
  - A new Req is accepted only from IDLE.
- Latency: Req rises at edge N (sampled in IDLE) → EXEC during cycle N+1 → Ack = 1 from edge N+2. Minimum 4 cycles per op including the Req release.
- Input changes: changes to Op, Sel or Entrada after capture have no effect. Req changes during EXEC are ignored.
- Arithmetic:
  - LOAD: r = Entrada.
  - ADD: r = acc + Entrada.
  - SUB: r = acc − Entrada.
  - CLR: r = 0.
  - All computed at DB+1 bits.
- Overflow: Ovf = 1 when operand signs match (ADD) or differ (SUB) and the result sign differs from acc's sign. LOAD and CLR force Ovf = 0.
- Overflow with SAT=0: the DB-bit wrapped result is written.
- Overflow with SAT=1: 0111..1 is written on positive overflow, 1000..0 on negative overflow; Ovf is still 1.
- Zero and Neg are taken from the value actually written.
- Flags hold until the next EXEC.
- Sel ≥ NACC (non-power-of-2 NACC): no write, flags unchanged, handshake still completes normally.
- Read port: Salida <= acc[RdSel] every cycle, 1-cycle latency.
  - A write and a read of the same index in the same cycle: Salida shows the old value that cycle and the new value one cycle later.
  - RdSel ≥ NACC gives Salida = 0.

Test Plan:
- Reset: hold Reset_n=0 for 2 cycles with Req=1 → all outputs 0, FSM in IDLE, no acc written; Salida reads 0 for every RdSel.
- LOAD then ADD (DB=16, NACC=4):
  - LOAD 0x0010 to acc2 → Ack at N+2, Zero=0, Neg=0.
  - Then ADD 0x0005 → acc2 = 0x0015; RdSel=2 gives Salida = 0x0015 one cycle after EXEC.
- Overflow wrap (SAT=0): LOAD 0x7FFF to acc0, then ADD 0x0001 → acc0 = 0x8000, Ovf=1, Neg=1.
- Overflow saturate (SAT=1): same sequence → acc0 = 0x7FFF, Ovf=1, Neg=0. Then SUB 0xFFFF (−1) → 0x7FFF, Ovf=1.
- SUB to zero plus channel isolation: acc1 = 3, SUB 3 → Zero=1, Ovf=0. acc0, acc2 and acc3 unchanged. Changing Entrada during EXEC has no effect.
- Handshake and reset abort:
  - Hold Req=1 in DONE for 5 cycles → Ack stays 1 and no second op runs.
  - Assert Reset_n=0 during EXEC of LOAD 0x1234 → acc unchanged (0) and Ack never rises.
